// File: rtl/bios_boot_watchdog.sv
// rtl/bios_boot_watchdog.sv - BIOS boot watchdog with automatic BIOS failover
//
// Times each boot from the PciReset release to PostDone. If POST stalls for
// TIMEOUT_SEC seconds, the block switches to the other BIOS and pulses
// ForceReset. Once MAX_RETRY switches have been used up, it latches BootFail.
//
// Ports:
//   Clk32KHz     in   sole clock, rising edge
//   Reset_N      in   asynchronous active-low reset
//   PciReset     in   platform reset (1 = released), asynchronous
//   Pwr_ok       in   main power good, asynchronous
//   PostDone     in   BIOS POST complete level, asynchronous
//   BiosSelReq   in   one-clock strobe: load Next_Bios from BiosSelVal
//   BiosSelVal   in   BIOS number for BiosSelReq
//   Active_Bios  out  BIOS currently steering chip select
//   Next_Bios    out  BIOS to use at the next boot
//   ForceReset   out  request to re-assert platform reset
//   BootFail     out  sticky: all retries exhausted
//   RetryCnt     out  automatic switches this power cycle
//   State        out  IDLE=0 BOOT=1 DONE=2 SWITCH=3 FAIL=4
module bios_boot_watchdog #(
    parameter int unsigned PRESCALE    = 32768,
    parameter int unsigned TIMEOUT_SEC = 120,
    parameter int unsigned MAX_RETRY   = 1,
    parameter int unsigned RST_PULSE   = 64
) (
    input  logic       Clk32KHz,
    input  logic       Reset_N,
    input  logic       PciReset,
    input  logic       Pwr_ok,
    input  logic       PostDone,
    input  logic       BiosSelReq,
    input  logic       BiosSelVal,
    output logic       Active_Bios,
    output logic       Next_Bios,
    output logic       ForceReset,
    output logic       BootFail,
    output logic [1:0] RetryCnt,
    output logic [2:0] State
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned PL_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [7:0]      SEC_LAST = 8'(TIMEOUT_SEC - 1);
    localparam logic [PL_W-1:0] PL_LAST  = PL_W'(RST_PULSE - 1);
    localparam logic [1:0]      MAX_R    = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BOOT   = 3'd1,
        ST_DONE   = 3'd2,
        ST_SWITCH = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    state_t          state;
    logic            prs_meta, prs, prs_d;
    logic            pok_meta, pok;
    logic            pdn_meta, pdn;
    logic [PS_W-1:0] presc;
    logic [7:0]      sec_cnt;
    logic [PL_W-1:0] pulse_cnt;

    logic prs_rise, prs_fall, tick, timeout;

    assign prs_rise = prs & ~prs_d;
    assign prs_fall = ~prs & prs_d;
    assign tick     = (presc == PS_LAST);
    // The timeout fires on the tick that would complete the last second. The
    // transition therefore lands exactly TIMEOUT_SEC*PRESCALE clocks after
    // BOOT entry, not one clock later.
    assign timeout  = tick && (sec_cnt == SEC_LAST);

    assign State = state;

    always_ff @(posedge Clk32KHz or negedge Reset_N) begin
        if (!Reset_N) begin
            state       <= ST_IDLE;
            prs_meta    <= 1'b0;
            prs         <= 1'b0;
            prs_d       <= 1'b0;
            pok_meta    <= 1'b0;
            pok         <= 1'b0;
            pdn_meta    <= 1'b0;
            pdn         <= 1'b0;
            presc       <= '0;
            sec_cnt     <= '0;
            pulse_cnt   <= '0;
            Active_Bios <= 1'b0;
            Next_Bios   <= 1'b0;
            ForceReset  <= 1'b0;
            BootFail    <= 1'b0;
            RetryCnt    <= 2'd0;
        end else begin
            prs_meta <= PciReset;
            prs      <= prs_meta;
            prs_d    <= prs;
            pok_meta <= Pwr_ok;
            pok      <= pok_meta;
            pdn_meta <= PostDone;
            pdn      <= pdn_meta;

            // A SWITCH entry below overrides this load on the same clock.
            if (BiosSelReq) begin
                Next_Bios <= BiosSelVal;
            end

            if (!pok) begin
                state      <= ST_IDLE;
                RetryCnt   <= 2'd0;
                BootFail   <= 1'b0;
                presc      <= '0;
                sec_cnt    <= '0;
                pulse_cnt  <= '0;
                ForceReset <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (prs_rise) begin
                            state       <= ST_BOOT;
                            Active_Bios <= Next_Bios;
                            presc       <= '0;
                            sec_cnt     <= '0;
                        end
                    end
                    ST_BOOT: begin
                        if (pdn) begin
                            state <= ST_DONE;
                        end else if (timeout) begin
                            if (RetryCnt < MAX_R) begin
                                state       <= ST_SWITCH;
                                Active_Bios <= ~Active_Bios;
                                Next_Bios   <= ~Active_Bios;
                                RetryCnt    <= (RetryCnt == 2'd3) ? 2'd3 : RetryCnt + 2'd1;
                                ForceReset  <= 1'b1;
                                pulse_cnt   <= '0;
                            end else begin
                                state    <= ST_FAIL;
                                BootFail <= 1'b1;
                            end
                        end else if (prs_fall) begin
                            state <= ST_IDLE;
                        end else begin
                            presc <= tick ? '0 : presc + PS_W'(1);
                            if (tick) begin
                                sec_cnt <= sec_cnt + 8'd1;
                            end
                        end
                    end
                    ST_SWITCH: begin
                        if (pulse_cnt == PL_LAST) begin
                            state      <= ST_IDLE;
                            ForceReset <= 1'b0;
                        end else begin
                            pulse_cnt <= pulse_cnt + PL_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (prs_fall) begin
                            state    <= ST_IDLE;
                            RetryCnt <= 2'd0;
                        end
                    end
                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bios_boot_watchdog.sv
// tb/tb_bios_boot_watchdog.sv - self-checking bench for bios_boot_watchdog
module tb_bios_boot_watchdog;

    localparam int PRESCALE    = 4;
    localparam int TIMEOUT_SEC = 3;
    localparam int MAX_RETRY   = 1;
    localparam int RST_PULSE   = 5;
    localparam int BOOT_CLKS   = PRESCALE * TIMEOUT_SEC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pci, pwr, pdn, sreq, sval;
    logic       act_bios, next_bios, force_rst, boot_fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    bios_boot_watchdog #(
        .PRESCALE   (PRESCALE),
        .TIMEOUT_SEC(TIMEOUT_SEC),
        .MAX_RETRY  (MAX_RETRY),
        .RST_PULSE  (RST_PULSE)
    ) dut (
        .Clk32KHz   (clk),
        .Reset_N    (rst_n),
        .PciReset   (pci),
        .Pwr_ok     (pwr),
        .PostDone   (pdn),
        .BiosSelReq (sreq),
        .BiosSelVal (sval),
        .Active_Bios(act_bios),
        .Next_Bios  (next_bios),
        .ForceReset (force_rst),
        .BootFail   (boot_fail),
        .RetryCnt   (retry_cnt),
        .State      (state)
    );

    always #5 clk = ~clk;

    // Reference model: inputs reach the logic two clocks after being sampled.
    // Boot and pulse durations are measured as elapsed clock counts.
    int m_state, m_rc, cyc, boot_t, sw_t;
    bit m_act, m_next, m_fail;
    bit hp[3], hw[3], hd[3];

    function automatic logic [8:0] ev(int st, bit a, bit n, bit fr, bit f, int rc);
        return {3'(st), a, n, fr, f, 2'(rc)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {state, act_bios, next_bios, force_rst, boot_fail, retry_cnt};
    endfunction

    function automatic logic [8:0] model_vec();
        return ev(m_state, m_act, m_next, (m_state == 3), m_fail, m_rc);
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (st/act/nxt/fr/fail/rc) t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_rc = 0; m_act = 0; m_next = 0; m_fail = 0;
        cyc = 0; boot_t = 0; sw_t = 0;
        for (int i = 0; i < 3; i++) begin
            hp[i] = 0; hw[i] = 0; hd[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit s_pci, s_pci_d, s_pok, s_pdn, rise, fall;
        int n_state, n_rc;
        bit n_act, n_next, n_fail;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cyc++;
        s_pci = hp[1]; s_pci_d = hp[2]; s_pok = hw[1]; s_pdn = hd[1];
        rise = s_pci && !s_pci_d;
        fall = !s_pci && s_pci_d;
        n_state = m_state; n_rc = m_rc; n_act = m_act; n_fail = m_fail;
        n_next = sreq ? sval : m_next;
        if (!s_pok) begin
            n_state = 0; n_rc = 0; n_fail = 0;
        end else begin
            case (m_state)
                0: if (rise) begin
                    n_state = 1; n_act = m_next; boot_t = cyc;
                end
                1: if (s_pdn) begin
                    n_state = 2;
                end else if (cyc - boot_t == BOOT_CLKS) begin
                    if (m_rc < MAX_RETRY) begin
                        n_state = 3; n_act = !m_act; n_next = !m_act;
                        n_rc = (m_rc < 3) ? m_rc + 1 : 3; sw_t = cyc;
                    end else begin
                        n_state = 4; n_fail = 1;
                    end
                end else if (fall) begin
                    n_state = 0;
                end
                2: if (fall) begin
                    n_state = 0; n_rc = 0;
                end
                3: if (cyc - sw_t == RST_PULSE) n_state = 0;
                default: ;
            endcase
        end
        m_state = n_state; m_rc = n_rc; m_act = n_act; m_next = n_next; m_fail = n_fail;
        hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = pci;
        hw[2] = hw[1]; hw[1] = hw[0]; hw[0] = pwr;
        hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = pdn;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    typedef struct {
        bit         pci, pwr, pdn, sreq, sval;
        int         ncyc;
        logic [8:0] exp;
    } vec_t;

    function automatic vec_t mk(bit p, bit w, bit d, bit r, bit v, int n, logic [8:0] e);
        vec_t t;
        t.pci = p; t.pwr = w; t.pdn = d; t.sreq = r; t.sval = v; t.ncyc = n; t.exp = e;
        return t;
    endfunction

    vec_t tbl[27];

    initial begin
        tbl[0]  = mk(0,1,0,0,0, 4,  ev(0,0,0,0,0,0));
        tbl[1]  = mk(1,1,0,0,0, 3,  ev(1,0,0,0,0,0));
        tbl[2]  = mk(1,1,0,0,0, 2,  ev(1,0,0,0,0,0));
        tbl[3]  = mk(1,1,1,0,0, 3,  ev(2,0,0,0,0,0));
        tbl[4]  = mk(0,1,1,0,0, 3,  ev(0,0,0,0,0,0));
        tbl[5]  = mk(0,1,0,0,0, 2,  ev(0,0,0,0,0,0));
        tbl[6]  = mk(1,1,0,0,0, 3,  ev(1,0,0,0,0,0));
        tbl[7]  = mk(1,1,0,0,0, 11, ev(1,0,0,0,0,0));
        tbl[8]  = mk(1,1,0,0,0, 1,  ev(3,1,1,1,0,1));
        tbl[9]  = mk(1,1,0,0,0, 4,  ev(3,1,1,1,0,1));
        tbl[10] = mk(1,1,0,0,0, 1,  ev(0,1,1,0,0,1));
        tbl[11] = mk(0,1,0,0,0, 3,  ev(0,1,1,0,0,1));
        tbl[12] = mk(1,1,0,0,0, 3,  ev(1,1,1,0,0,1));
        tbl[13] = mk(0,1,0,0,0, 3,  ev(0,1,1,0,0,1));
        tbl[14] = mk(1,1,0,0,0, 3,  ev(1,1,1,0,0,1));
        tbl[15] = mk(1,1,0,0,0, 12, ev(4,1,1,0,1,1));
        tbl[16] = mk(1,0,0,0,0, 3,  ev(0,1,1,0,0,0));
        tbl[17] = mk(0,1,0,0,0, 3,  ev(0,1,1,0,0,0));
        tbl[18] = mk(0,1,0,1,0, 1,  ev(0,1,0,0,0,0));
        tbl[19] = mk(1,1,0,0,0, 3,  ev(1,0,0,0,0,0));
        tbl[20] = mk(1,1,0,0,0, 9,  ev(1,0,0,0,0,0));
        tbl[21] = mk(1,1,1,0,0, 3,  ev(2,0,0,0,0,0));
        tbl[22] = mk(0,1,0,0,0, 3,  ev(0,0,0,0,0,0));
        tbl[23] = mk(0,1,0,1,1, 1,  ev(0,0,1,0,0,0));
        tbl[24] = mk(1,1,0,0,0, 3,  ev(1,1,1,0,0,0));
        tbl[25] = mk(1,1,1,0,0, 3,  ev(2,1,1,0,0,0));
        tbl[26] = mk(0,1,0,0,0, 3,  ev(0,1,1,0,0,0));

        rst_n = 1'b0; pci = 0; pwr = 0; pdn = 0; sreq = 0; sval = 0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        check("reset_state", dut_vec(), ev(0,0,0,0,0,0));

        foreach (tbl[i]) begin
            pci = tbl[i].pci; pwr = tbl[i].pwr; pdn = tbl[i].pdn;
            sreq = tbl[i].sreq; sval = tbl[i].sval;
            for (int c = 0; c < tbl[i].ncyc; c++) begin
                step();
                sreq = 0;
            end
            check($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
        end

        // BiosSelReq on the SWITCH entry clock: the switch wins.
        pci = 1;
        for (int c = 0; c < 3; c++) step();
        check("sel_collide_boot", dut_vec(), ev(1,1,1,0,0,0));
        for (int c = 0; c < BOOT_CLKS - 1; c++) step();
        sreq = 1; sval = 1;
        step();
        sreq = 0;
        check("sel_collide_switch", dut_vec(), ev(3,0,0,1,0,1));
        step();
        step();
        check("switch_pulse_mid", {8'd0, force_rst}, 9'd1);

        // Reset_N asserted mid-SWITCH drops ForceReset without waiting for a clock.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_fr", {8'd0, force_rst}, 9'd0);
        check("async_reset_all", dut_vec(), ev(0,0,0,0,0,0));
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        check("after_reset", dut_vec(), ev(0,0,0,0,0,0));
        pci = 0;
        for (int c = 0; c < 4; c++) step();

        for (int seg = 0; seg < 300; seg++) begin
            int len;
            pci = 1'($urandom_range(0, 1));
            pwr = ($urandom_range(0, 15) != 0);
            pdn = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 20);
            for (int c = 0; c < len; c++) begin
                sreq = ($urandom_range(0, 9) == 0);
                sval = 1'($urandom_range(0, 1));
                step();
            end
            sreq = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bios_boot_watchdog.md
BIOS_BOOT_WATCHDOG -- requirements
Module: bios_boot_watchdog

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 32768: Clk32KHz cycles per 1 s tick.
REQ-002 The block SHALL have parameter TIMEOUT_SEC, default 120: ticks allowed from boot start to PostDone; 8-bit; legal range 1..255.
REQ-003 The block SHALL have parameter MAX_RETRY, default 1: number of automatic BIOS switches before declaring failure; 2-bit.
REQ-004 The block SHALL have parameter RST_PULSE, default 64: ForceReset width in clocks; legal range >=1.
REQ-005 Port Clk32KHz  in  1  sole clock; all flops on rising edge.
REQ-006 Port Reset_N  in  1  asynchronous, active-low reset.
REQ-007 Port PciReset  in  1  platform reset, high = released; asynchronous to Clk32KHz.
REQ-008 Port Pwr_ok  in  1  main power good; asynchronous.
REQ-009 Port PostDone  in  1  BIOS POST-complete level; asynchronous.
REQ-010 Port BiosSelReq  in  1  one-clock strobe requesting a next-boot BIOS change; synchronous.
REQ-011 Port BiosSelVal  in  1  BIOS number loaded by BiosSelReq.
REQ-012 Port Active_Bios  out  1  BIOS driving chip-select steering.
REQ-013 Port Next_Bios  out  1  BIOS to be used at next boot.
REQ-014 Port ForceReset  out  1  request to the reset logic to re-assert platform reset.
REQ-015 Port BootFail  out  1  sticky: all retries exhausted.
REQ-016 Port RetryCnt  out  2  automatic switches performed this power cycle.
REQ-017 Port State  out  3  encoded FSM state: IDLE=0, BOOT=1, DONE=2, SWITCH=3, FAIL=4.

Function
REQ-018 PciReset, Pwr_ok and PostDone SHALL each pass through a 2-flop synchronizer; all logic SHALL use the synchronized versions (prs, pok, pdn).
REQ-019 The PciReset rising and falling edges SHALL be detected from prs and its 1-clock delayed copy.
REQ-020 In IDLE, on a prs rising edge with pok=1, the FSM SHALL go to BOOT, load Active_Bios<=Next_Bios, and clear the prescaler and the seconds counter.
REQ-021 In BOOT, the prescaler SHALL count 0..PRESCALE-1, emitting a tick at PRESCALE-1 and wrapping; each tick SHALL increment the seconds counter.
REQ-022 In BOOT, pdn=1 SHALL cause a transition to DONE, and SHALL take priority over a timeout in the same cycle.
REQ-023 In BOOT, when the seconds counter equals TIMEOUT_SEC, the FSM SHALL go to SWITCH if RetryCnt<MAX_RETRY, else to FAIL; the timeout SHALL fire exactly TIMEOUT_SEC*PRESCALE clocks after BOOT entry.
REQ-024 In BOOT, a prs falling edge before timeout SHALL return the FSM to IDLE with no switch and no RetryCnt change.
REQ-025 On the SWITCH entry clock, the block SHALL set Active_Bios<=~Active_Bios, Next_Bios<=~Active_Bios, and RetryCnt<=RetryCnt+1; RetryCnt SHALL saturate at 3.
REQ-026 In SWITCH, ForceReset SHALL be 1 for exactly RST_PULSE clocks, after which the FSM SHALL go to IDLE.
REQ-027 ForceReset SHALL be 0 in every state other than SWITCH.
REQ-028 In DONE, a prs falling edge SHALL return the FSM to IDLE and clear RetryCnt to 0.
REQ-029 In FAIL, the block SHALL drive BootFail=1 and hold Active_Bios; FAIL SHALL be left only by pok=0 or Reset_N.
REQ-030 pok=0 in any state SHALL force IDLE on the next clock and clear RetryCnt, BootFail, the prescaler, the seconds counter and ForceReset; Active_Bios and Next_Bios SHALL be preserved.
REQ-031 BiosSelReq=1 SHALL load Next_Bios<=BiosSelVal in any state, except on a SWITCH entry clock, where REQ-025 SHALL win.
REQ-032 Active_Bios SHALL change only on BOOT entry or SWITCH entry.
REQ-033 All outputs SHALL be driven directly from registers, with no combinational paths from inputs to outputs.

Reset
REQ-034 While Reset_N=0, the block SHALL asynchronously force State=IDLE, Active_Bios=0, Next_Bios=0, ForceReset=0, BootFail=0, RetryCnt=0, and clear all synchronizers, counters and edge registers.
REQ-035 Reset_N deassertion SHALL take effect on the next rising clock edge; assertion mid-SWITCH SHALL immediately drop ForceReset.

Verification (PRESCALE=4, TIMEOUT_SEC=3, MAX_RETRY=1, RST_PULSE=5)
REQ-036 Scenario: Pwr_ok=1, PciReset 0->1, PostDone=1 after 5 clocks -> State BOOT then DONE; Active_Bios=0; ForceReset never asserted.
REQ-037 Scenario: PciReset rises, PostDone held 0 -> SWITCH 12 clocks after BOOT entry; Active_Bios=1, Next_Bios=1, RetryCnt=1; ForceReset high for exactly 5 clocks; State=IDLE afterwards.
REQ-038 Scenario: the timeout of REQ-037 is repeated after a further PciReset 0->1 -> State=FAIL, BootFail=1, Active_Bios stays 1, ForceReset=0; then Pwr_ok=0 -> IDLE, BootFail=0, RetryCnt=0.
REQ-039 Scenario: BiosSelReq with BiosSelVal=1 while in IDLE, then PciReset rises -> Next_Bios=1, and Active_Bios=1 on BOOT entry.
REQ-040 Scenario: PostDone rises on the same clock as the timeout -> DONE; RetryCnt unchanged.
REQ-041 Scenario: Reset_N pulsed low for 2 clocks during SWITCH -> ForceReset=0 immediately; all outputs return to reset values.
